// File: rtl/pwm_multi.sv
// N-channel PWM sharing one programmable-period counter (edge or center aligned).
// Duty, period and mode are double-buffered and move to the active set only on a load.
module pwm_multi #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  top,
  input  logic              center,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_duty,
  output logic [NUM_CH-1:0] PWM_sig,
  output logic              period_start
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [WIDTH-1:0] cnt, cnt_nxt;
  dir_t             dir, dir_nxt;
  logic             load;

  logic [WIDTH-1:0] top_sh, top_act;
  logic             center_sh, center_act;
  logic [WIDTH-1:0] duty_sh  [NUM_CH];
  logic [WIDTH-1:0] duty_act [NUM_CH];

  // Counter defaults to 0/up: covers disable, top_act=0 and every wrap point.
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = UP;
    if (en && (top_act != '0)) begin
      if (!center_act) begin
        if (cnt < top_act) cnt_nxt = cnt + WIDTH'(1);
      end else if (dir == UP) begin
        if (cnt < top_act) begin
          cnt_nxt = cnt + WIDTH'(1);
        end else begin
          cnt_nxt = top_act - WIDTH'(1);
          dir_nxt = DOWN;
        end
      end else if (cnt > WIDTH'(1)) begin
        cnt_nxt = cnt - WIDTH'(1);
        dir_nxt = DOWN;
      end else if (cnt == '0) begin
        cnt_nxt = WIDTH'(1);
      end
    end
  end

  assign load = (cnt_nxt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      dir          <= UP;
      top_sh       <= '0;
      top_act      <= '0;
      center_sh    <= 1'b0;
      center_act   <= 1'b0;
      PWM_sig      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      top_sh    <= top;
      center_sh <= center;
      if (wr_en && (32'(wr_ch) < NUM_CH)) duty_sh[wr_ch] <= wr_duty;
      // Load takes the pre-edge shadow, so a same-cycle write waits for the next load.
      if (load) begin
        top_act    <= top_sh;
        center_act <= center_sh;
        for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
      end
      period_start <= en && (cnt == '0);
      for (int i = 0; i < NUM_CH; i++) PWM_sig[i] <= en && (cnt < duty_act[i]);
    end
  end

endmodule
